outbound_fifo_ctrl: RTL and testbench

Single-clock controller for the outbound-port FIFO. It drives the LSRAM wrapper's write and read ports (address, enable and data) and presents a first-word-fall-through (FWFT) interface to the egress scheduler. A 2-entry output stage hides the RAM's 1-cycle read latency so that back-to-back pops run at full rate. Occupancy, FULL/EMPTY, almost-flags and error pulses come from registered state.

---
 rtl/outbound_fifo_pkg.sv | 9 +
 rtl/fwft_out_stage.sv | 54 +++++
 rtl/outbound_fifo_ctrl.sv | 93 +++++++++
 tb/tb_outbound_fifo_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/outbound_fifo_pkg.sv
// Shared sizing defaults for the outbound-port FIFO controller.
package outbound_fifo_pkg;
  localparam int DEF_DATA_WIDTH    = 32;
  localparam int DEF_ADDR_WIDTH    = 7;
  localparam int DEPTH             = 2 ** DEF_ADDR_WIDTH;
  localparam int CNT_WIDTH         = DEF_ADDR_WIDTH + 2;
  localparam int DEF_AFULL_THRESH  = 120;
  localparam int DEF_AEMPTY_THRESH = 4;
endpackage

// File: rtl/fwft_out_stage.sv
// Two-entry head/skid buffer behind the RAM read port; q is the head word.
// A load into a full stage cannot occur because reads are only issued when a slot is free.
module fwft_out_stage
  import outbound_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] q,
  output logic [1:0]            out_cnt
);
  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] skid;

  always_ff @(posedge clk) begin
    if (reset) begin
      head    <= '0;
      skid    <= '0;
      out_cnt <= 2'd0;
    end else begin
      case (out_cnt)
        2'd0: begin
          if (load) begin
            head    <= load_data;
            out_cnt <= 2'd1;
          end
        end
        2'd1: begin
          if (pop && load) begin
            head <= load_data;
          end else if (pop) begin
            out_cnt <= 2'd0;
          end else if (load) begin
            skid    <= load_data;
            out_cnt <= 2'd2;
          end
        end
        default: begin
          if (pop) begin
            head <= skid;
            if (load) skid <= load_data;
            else      out_cnt <= 2'd1;
          end
        end
      endcase
    end
  end

  assign q = head;
endmodule

// File: rtl/outbound_fifo_ctrl.sv
// Outbound-port FIFO controller: drives the LSRAM wrapper and presents an FWFT head word.
// Push-to-Q latency is two edges into an empty FIFO; full-rate pops while the RAM holds data.
module outbound_fifo_ctrl
  import outbound_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int AFULL_THRESH  = DEF_AFULL_THRESH,
  parameter int AEMPTY_THRESH = DEF_AEMPTY_THRESH
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic                  WE,
  input  logic [DATA_WIDTH-1:0] DATA,
  input  logic                  RE,
  output logic [DATA_WIDTH-1:0] Q,
  output logic                  FULL,
  output logic                  AFULL,
  output logic                  EMPTY,
  output logic                  AEMPTY,
  output logic [ADDR_WIDTH+1:0] WRCNT,
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW,
  output logic [ADDR_WIDTH-1:0] RAM_WADDR,
  output logic                  RAM_WEN,
  output logic [DATA_WIDTH-1:0] RAM_WDATA,
  output logic [ADDR_WIDTH-1:0] RAM_RADDR,
  output logic                  RAM_REN,
  input  logic [DATA_WIDTH-1:0] RAM_RDATA
);
  localparam int CW = ADDR_WIDTH + 2;
  localparam logic [ADDR_WIDTH:0] RAM_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  logic [ADDR_WIDTH:0]   ram_cnt;
  logic                  rd_pend;
  logic [1:0]            out_cnt;
  logic                  accept;
  logic                  pop;
  logic                  issue;
  logic [2:0]            out_need;

  assign accept   = WE & ~FULL;
  assign pop      = RE & ~EMPTY;
  // Output slots still committed after this cycle; a new read needs one of the two free.
  assign out_need = {1'b0, out_cnt} + {2'b00, rd_pend} - {2'b00, pop};
  assign issue    = (ram_cnt != '0) && (out_need < 3'd2);

  assign FULL   = (ram_cnt == RAM_DEPTH);
  assign EMPTY  = (out_cnt == 2'd0);
  assign WRCNT  = {1'b0, ram_cnt} + {{(CW-1){1'b0}}, rd_pend} + {{(CW-2){1'b0}}, out_cnt};
  assign AFULL  = (WRCNT >= CW'(AFULL_THRESH));
  assign AEMPTY = (WRCNT <= CW'(AEMPTY_THRESH));

  assign RAM_WEN   = accept;
  assign RAM_WADDR = wptr;
  assign RAM_WDATA = DATA;
  assign RAM_REN   = issue;
  assign RAM_RADDR = rptr;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      wptr      <= '0;
      rptr      <= '0;
      ram_cnt   <= '0;
      rd_pend   <= 1'b0;
      OVERFLOW  <= 1'b0;
      UNDERFLOW <= 1'b0;
    end else begin
      if (accept) wptr <= wptr + ADDR_WIDTH'(1);
      if (issue)  rptr <= rptr + ADDR_WIDTH'(1);
      case ({accept, issue})
        2'b10:   ram_cnt <= ram_cnt + (ADDR_WIDTH+1)'(1);
        2'b01:   ram_cnt <= ram_cnt - (ADDR_WIDTH+1)'(1);
        default: ;
      endcase
      rd_pend   <= issue;
      OVERFLOW  <= WE & FULL;
      UNDERFLOW <= RE & EMPTY;
    end
  end

  fwft_out_stage #(.DATA_WIDTH(DATA_WIDTH)) u_out_stage (
    .clk       (CLOCK),
    .reset     (RESET),
    .load      (rd_pend),
    .load_data (RAM_RDATA),
    .pop       (pop),
    .q         (Q),
    .out_cnt   (out_cnt)
  );
endmodule

// File: tb/tb_outbound_fifo_ctrl.sv
// Directed bench for outbound_fifo_ctrl with a behavioural 1-cycle-latency RAM and an order scoreboard.
module tb_outbound_fifo_ctrl;
  import outbound_fifo_pkg::*;

  localparam int DW   = DEF_DATA_WIDTH;
  localparam int AW   = DEF_ADDR_WIDTH;
  localparam int MAXW = DEPTH + 2;

  logic                 CLOCK;
  logic                 RESET;
  logic                 WE;
  logic [DW-1:0]        DATA;
  logic                 RE;
  logic [DW-1:0]        Q;
  logic                 FULL;
  logic                 AFULL;
  logic                 EMPTY;
  logic                 AEMPTY;
  logic [CNT_WIDTH-1:0] WRCNT;
  logic                 OVERFLOW;
  logic                 UNDERFLOW;
  logic [AW-1:0]        RAM_WADDR;
  logic                 RAM_WEN;
  logic [DW-1:0]        RAM_WDATA;
  logic [AW-1:0]        RAM_RADDR;
  logic                 RAM_REN;
  logic [DW-1:0]        RAM_RDATA;

  outbound_fifo_ctrl dut (
    .CLOCK     (CLOCK),
    .RESET     (RESET),
    .WE        (WE),
    .DATA      (DATA),
    .RE        (RE),
    .Q         (Q),
    .FULL      (FULL),
    .AFULL     (AFULL),
    .EMPTY     (EMPTY),
    .AEMPTY    (AEMPTY),
    .WRCNT     (WRCNT),
    .OVERFLOW  (OVERFLOW),
    .UNDERFLOW (UNDERFLOW),
    .RAM_WADDR (RAM_WADDR),
    .RAM_WEN   (RAM_WEN),
    .RAM_WDATA (RAM_WDATA),
    .RAM_RADDR (RAM_RADDR),
    .RAM_REN   (RAM_REN),
    .RAM_RDATA (RAM_RDATA)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  logic [DW-1:0] mem [0:DEPTH-1];
  always @(posedge CLOCK) begin
    if (RAM_WEN) mem[RAM_WADDR] <= RAM_WDATA;
    if (RAM_REN) RAM_RDATA <= mem[RAM_RADDR];
  end

  int            tests;
  int            fails;
  logic [DW-1:0] sb[$];
  logic          exp_ovf;
  logic          exp_udf;
  logic [AW-1:0] exp_waddr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: entered and left at posedge+1 so registered outputs are settled.
  task automatic do_cycle(input logic we, input logic [DW-1:0] d, input logic re);
    int   n;
    logic acc;
    logic pp;
    n = sb.size();
    check("overflow", OVERFLOW, exp_ovf);
    check("underflow", UNDERFLOW, exp_udf);
    check("wrcnt", WRCNT, n);
    check("afull", AFULL, n >= DEF_AFULL_THRESH);
    check("aempty", AEMPTY, n <= DEF_AEMPTY_THRESH);
    WE   = we;
    DATA = d;
    RE   = re;
    acc  = we && (n < MAXW);
    pp   = re && (n > 0);
    #1;
    check("ram_wen", RAM_WEN, acc);
    if (acc) begin
      check("ram_waddr", RAM_WADDR, exp_waddr);
      exp_waddr = exp_waddr + 1'b1;
      sb.push_back(d);
    end
    if (pp) begin
      check("empty_at_pop", EMPTY, 1'b0);
      check("q_order", Q, sb[0]);
      sb.delete(0);
    end
    exp_ovf = we && !acc;
    exp_udf = re && !pp;
    @(posedge CLOCK);
    #1;
    WE = 1'b0;
    RE = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    exp_ovf = 1'b0;
    exp_udf = 1'b0;
    exp_waddr = '0;
    RESET = 1'b1;
    WE = 1'b0;
    RE = 1'b0;
    DATA = '0;
    repeat (2) @(posedge CLOCK);
    #1;
    RESET = 1'b0;

    // Reset state
    check("rst_q", Q, 0);
    check("rst_empty", EMPTY, 1'b1);
    check("rst_aempty", AEMPTY, 1'b1);
    check("rst_full", FULL, 1'b0);
    check("rst_afull", AFULL, 1'b0);
    check("rst_wrcnt", WRCNT, 0);
    check("rst_ram_wen", RAM_WEN, 1'b0);
    check("rst_ram_ren", RAM_REN, 1'b0);
    check("rst_ovf", OVERFLOW, 1'b0);
    check("rst_udf", UNDERFLOW, 1'b0);
    do_cycle(1'b0, '0, 1'b0);

    // Single push latency
    do_cycle(1'b1, 32'hDEADBEEF, 1'b0);
    check("lat_ren_k", RAM_REN, 1'b1);
    check("lat_raddr_k", RAM_RADDR, 0);
    check("lat_empty_k", EMPTY, 1'b1);
    do_cycle(1'b0, '0, 1'b0);
    check("lat_ren_k1", RAM_REN, 1'b0);
    check("lat_empty_k1", EMPTY, 1'b1);
    do_cycle(1'b0, '0, 1'b0);
    check("lat_empty_k2", EMPTY, 1'b0);
    check("lat_q_k2", Q, 32'hDEADBEEF);
    do_cycle(1'b0, '0, 1'b1);
    check("lat_empty_after_pop", EMPTY, 1'b1);
    check("lat_wrcnt_after_pop", WRCNT, 0);

    // Fill to full, then overflow
    for (int i = 0; i < MAXW; i++) begin
      check("fill_full_low", FULL, 1'b0);
      do_cycle(1'b1, i, 1'b0);
    end
    check("fill_full", FULL, 1'b1);
    check("fill_wrcnt", WRCNT, MAXW);
    do_cycle(1'b1, 32'h0BAD0BAD, 1'b0);
    do_cycle(1'b0, '0, 1'b0);
    check("ovf_wrcnt_hold", WRCNT, MAXW);
    do_cycle(1'b0, '0, 1'b0);

    // Drain at full rate, then underflow
    for (int i = 0; i < MAXW; i++) do_cycle(1'b0, '0, 1'b1);
    check("drain_empty", EMPTY, 1'b1);
    check("drain_full", FULL, 1'b0);
    do_cycle(1'b0, '0, 1'b1);
    do_cycle(1'b0, '0, 1'b0);

    // Streaming across pointer wrap
    for (int i = 0; i < 3; i++) do_cycle(1'b1, 32'h1000 + i, 1'b0);
    for (int i = 3; i < 303; i++) do_cycle(1'b1, 32'h1000 + i, 1'b1);
    for (int i = 0; i < 8 && sb.size() > 0; i++) do_cycle(1'b0, '0, 1'b1);
    check("stream_drained", EMPTY, 1'b1);
    do_cycle(1'b0, '0, 1'b0);

    // Reset with data stored and a read in flight
    for (int i = 0; i < 50; i++) do_cycle(1'b1, 32'h100 + i, 1'b0);
    do_cycle(1'b0, '0, 1'b1);
    RESET = 1'b1;
    @(posedge CLOCK);
    #1;
    RESET = 1'b0;
    sb.delete();
    exp_ovf = 1'b0;
    exp_udf = 1'b0;
    exp_waddr = '0;
    check("mid_rst_empty", EMPTY, 1'b1);
    check("mid_rst_wrcnt", WRCNT, 0);
    check("mid_rst_q", Q, 0);
    do_cycle(1'b1, 32'h55, 1'b0);
    do_cycle(1'b0, '0, 1'b0);
    check("post_rst_empty_k1", EMPTY, 1'b1);
    do_cycle(1'b0, '0, 1'b0);
    check("post_rst_empty_k2", EMPTY, 1'b0);
    check("post_rst_q", Q, 32'h55);
    do_cycle(1'b0, '0, 1'b1);
    do_cycle(1'b0, '0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
